adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 10 +
 rtl/carry_select_adder.sv | 23 ++
 rtl/adder_arbiter.sv | 102 ++++++++++
 tb/tb_adder_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared width constant and FSM state encoding for adder_arbiter
package adder_arb_pkg;
  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - unsigned WIDTH-bit carry-select adder with carry-out
import adder_arb_pkg::*;

module carry_select_adder (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             CO
);
  localparam int HALF = WIDTH / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum_c0;
  logic [HALF:0] hi_sum_c1;

  // Upper half is computed for both carry-ins and selected by the lower carry.
  assign lo_sum    = {1'b0, A[HALF-1:0]} + {1'b0, B[HALF-1:0]};
  assign hi_sum_c0 = {1'b0, A[WIDTH-1:HALF]} + {1'b0, B[WIDTH-1:HALF]};
  assign hi_sum_c1 = {1'b0, A[WIDTH-1:HALF]} + {1'b0, B[WIDTH-1:HALF]} + {{HALF{1'b0}}, 1'b1};

  assign Sum = {(lo_sum[HALF] ? hi_sum_c1[HALF-1:0] : hi_sum_c0[HALF-1:0]), lo_sum[HALF-1:0]};
  assign CO  = lo_sum[HALF] ? hi_sum_c1[HALF] : hi_sum_c0[HALF];
endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder between two requesters
import adder_arb_pkg::*;

module adder_arbiter (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Done0,
  output logic             Done1,
  output logic             Busy
);
  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             winner;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;

  carry_select_adder u_adder (
    .A   (opa_q),
    .B   (opb_q),
    .Sum (add_sum),
    .CO  (add_co)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    co_d    = co_q;
    // On a tie the requester that was not granted last wins.
    winner  = (Req0 && Req1) ? ~last_q : Req1;
    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          gnt_d   = winner ? 2'b10 : 2'b01;
          last_d  = winner;
          opa_d   = winner ? A1 : A0;
          opb_d   = winner ? B1 : B0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d   = add_sum;
        co_d    = add_co;
        state_d = RESP;
      end
      RESP: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign Gnt0  = gnt_q[0];
  assign Gnt1  = gnt_q[1];
  assign Done0 = (state_q == RESP) && gnt_q[0];
  assign Done1 = (state_q == RESP) && gnt_q[1];
  assign Busy  = (state_q != IDLE);
  assign Sum   = sum_q;
  assign CO    = co_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [15:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic        Gnt0, Gnt1, CO, Done0, Done1, Busy;
  logic [15:0] Sum;

  int errors = 0;
  int checks = 0;

  adder_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Sum(Sum), .CO(CO),
    .Done0(Done0), .Done1(Done1), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Req0 = 1'b0; Req1 = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    checks++;
    if ({Gnt0, Gnt1, Done0, Done1, Busy, CO, Sum} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b co=%b sum=%h expected all zero",
               Gnt0, Gnt1, Done0, Done1, Busy, CO, Sum);
    end
    do_reset();
  endtask

  task automatic test_single_req0();
    A0 = 16'h0001; B0 = 16'hFFFF; Req0 = 1'b1;
    tick();
    checks++;
    if ({Gnt0, Gnt1, Busy, Done0} !== 4'b1010) begin
      errors++;
      $display("FAIL single_accept: got gnt0=%b gnt1=%b busy=%b done0=%b expected 1 0 1 0", Gnt0, Gnt1, Busy, Done0);
    end
    tick();
    checks++;
    if ({Done0, Done1, Gnt0, CO, Sum} !== {4'b1011, 16'h0000}) begin
      errors++;
      $display("FAIL single_done: got done0=%b done1=%b gnt0=%b co=%b sum=%h expected 1 0 1 1 0000",
               Done0, Done1, Gnt0, CO, Sum);
    end
    Req0 = 1'b0;
    tick();
    checks++;
    if ({Gnt0, Done0, Busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: got gnt0=%b done0=%b busy=%b expected 0 0 0", Gnt0, Done0, Busy);
    end
  endtask

  task automatic test_tie();
    do_reset();
    A0 = 16'h0002; B0 = 16'hFFFF; A1 = 16'h0003; B1 = 16'hFFFF;
    Req0 = 1'b1; Req1 = 1'b1;
    tick();
    checks++;
    if ({Gnt0, Gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL tie_first_grant: got gnt0=%b gnt1=%b expected 1 0", Gnt0, Gnt1);
    end
    tick();
    checks++;
    if ({Done0, Done1, CO, Sum} !== {3'b101, 16'h0001}) begin
      errors++;
      $display("FAIL tie_done0: got done0=%b done1=%b co=%b sum=%h expected 1 0 1 0001", Done0, Done1, CO, Sum);
    end
    Req0 = 1'b0;
    tick();
    tick();
    checks++;
    if ({Gnt0, Gnt1, Done1} !== 3'b010) begin
      errors++;
      $display("FAIL tie_second_grant: got gnt0=%b gnt1=%b done1=%b expected 0 1 0", Gnt0, Gnt1, Done1);
    end
    tick();
    checks++;
    if ({Done0, Done1, CO, Sum} !== {3'b011, 16'h0002}) begin
      errors++;
      $display("FAIL tie_done1: got done0=%b done1=%b co=%b sum=%h expected 0 1 1 0002", Done0, Done1, CO, Sum);
    end
    Req1 = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic [15:0] exp_sum;
    logic        exp_co;
    logic        exp_g1;
    do_reset();
    A0 = 16'h1000; B0 = 16'h0234; A1 = 16'h8000; B1 = 16'h8001;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_g1  = (t % 2) == 1;
      exp_sum = exp_g1 ? 16'h0001 : 16'h1234;
      exp_co  = exp_g1;
      tick();
      checks++;
      if ({Gnt0, Gnt1} !== {~exp_g1, exp_g1}) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got gnt0=%b gnt1=%b expected %b %b", t, Gnt0, Gnt1, ~exp_g1, exp_g1);
      end
      tick();
      checks++;
      if ({Done0, Done1, CO, Sum} !== {~exp_g1, exp_g1, exp_co, exp_sum}) begin
        errors++;
        $display("FAIL alt_done[%0d]: got done0=%b done1=%b co=%b sum=%h expected %b %b %b %h",
                 t, Done0, Done1, CO, Sum, ~exp_g1, exp_g1, exp_co, exp_sum);
      end
      tick();
      checks++;
      if ({Done0, Done1, Busy} !== 3'b000) begin
        errors++;
        $display("FAIL alt_idle[%0d]: got done0=%b done1=%b busy=%b expected 0 0 0", t, Done0, Done1, Busy);
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
  endtask

  task automatic test_req1_hold();
    A1 = 16'h0000; B1 = 16'hF0FF; Req1 = 1'b1;
    tick();
    checks++;
    if ({Gnt0, Gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL hold_grant: got gnt0=%b gnt1=%b expected 0 1", Gnt0, Gnt1);
    end
    tick();
    checks++;
    if ({Done1, CO, Sum} !== {2'b10, 16'hF0FF}) begin
      errors++;
      $display("FAIL hold_done: got done1=%b co=%b sum=%h expected 1 0 f0ff", Done1, CO, Sum);
    end
    Req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i > 0) begin
        checks++;
        if ({Busy, CO, Sum} !== {2'b00, 16'hF0FF}) begin
          errors++;
          $display("FAIL hold_idle[%0d]: got busy=%b co=%b sum=%h expected 0 0 f0ff", i, Busy, CO, Sum);
        end
      end
    end
  endtask

  task automatic test_reset_mid_add();
    A0 = 16'h0001; B0 = 16'hFFFF; Req0 = 1'b1;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Gnt0, Gnt1, Done0, Done1, Busy, CO, Sum} !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid_add: got gnt=%b%b done=%b%b busy=%b co=%b sum=%h expected all zero",
               Gnt0, Gnt1, Done0, Done1, Busy, CO, Sum);
    end
    Req0 = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if ({Done0, Done1, Busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_done: got done0=%b done1=%b busy=%b expected 0 0 0", Done0, Done1, Busy);
    end
    A0 = 16'h0005; B0 = 16'h0007; Req0 = 1'b1;
    tick();
    tick();
    checks++;
    if ({Done0, CO, Sum} !== {2'b10, 16'h000C}) begin
      errors++;
      $display("FAIL reset_resume: got done0=%b co=%b sum=%h expected 1 0 000c", Done0, CO, Sum);
    end
    Req0 = 1'b0;
    tick();
  endtask

  task automatic test_operand_change();
    A0 = 16'h0001; B0 = 16'hFFFF; Req0 = 1'b1;
    tick();
    A0 = 16'h1234;
    tick();
    checks++;
    if ({Done0, CO, Sum} !== {2'b11, 16'h0000}) begin
      errors++;
      $display("FAIL operand_latch: got done0=%b co=%b sum=%h expected 1 1 0000", Done0, CO, Sum);
    end
    Req0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_tie();
    test_alternate();
    test_req1_hold();
    test_reset_mid_add();
    test_operand_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
